mic_capture_ctrl: RTL
=====================

Name: mic_capture_ctrl

Overview:
Capture controller for the codec ADC receive path. Generates the adclrc frame clock in bclk cycles and sequences burst or continuous capture windows aligned to frame boundaries. Accepts samples from the mic receiver's valid/data pulse and presents them downstream through a one-entry ready/valid slot. Flags overrun when the consumer stalls.

Parameters:
N, 16, sample width in bits; must match the receiver's sample width.
FRAME_BCLKS, 384, bclk cycles per adclrc period (18.432 MHz / 384 = 48 kHz); must be even and ≥ 2*(N+2).
BURST_W, 16, width of burst_len and sample_count.

Ports:
bclk  in  1  bit clock; the only clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins a capture.
stop  in  1  single-cycle pulse; ends the capture early.
burst_len  in  BURST_W  samples to capture; 0 = continuous until stop.
adclrc  out  1  frame clock to the codec and the receiver.
rx_valid  in  1  one-cycle sample strobe from the receiver.
rx_data  in  N  sample from the receiver; valid when rx_valid=1.
out_valid  out  1  output slot holds a sample.
out_data  out  N  sample in the output slot.
out_ready  in  1  consumer accepts when out_valid & out_ready.
busy  out  1  1 in every state except IDLE.
done  out  1  one-cycle pulse at the end of a capture.
overrun  out  1  sticky; a sample was dropped.
clear_overrun  in  1  synchronous clear of overrun.
sample_count  out  BURST_W  samples accepted in the current or last capture.
timeout  out  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): frame_cnt=0, adclrc=0, state=IDLE, out_valid=0, out_data=0, busy=0, done=0, overrun=0, sample_count=0, timeout=0.
- Frame timing: frame_cnt free-runs 0..FRAME_BCLKS-1 and wraps to 0. It runs in every state.
  - adclrc is registered: adclrc <= (frame_cnt < FRAME_BCLKS/2). Its first rising edge occurs 1 cycle after reset release.
  - frame_start = (frame_cnt == 0).
- IDLE:
  - start=1 → ARM. Latch burst_len and clear sample_count to 0 on the same edge.
  - stop is ignored in IDLE. start is ignored in every state except IDLE.
- ARM:
  - frame_start → CAPTURE. A partially received frame is never captured.
  - stop → DONE; sample_count stays 0.
  - rx_valid is ignored in ARM.
- CAPTURE, on rx_valid=1:
  - If the slot is free (out_valid=0, or out_valid & out_ready this cycle): load out_data<=rx_data and set out_valid=1 next cycle. sample_count increments, saturating at all-ones.
  - Otherwise: drop the sample, set overrun=1, and leave sample_count unchanged.
- CAPTURE exit:
  - Go to DRAIN when the latched burst_len≠0 and the accepted count reaches it (same edge as the final accept).
  - Go to DRAIN on stop. If rx_valid arrives in the same cycle as stop, that sample is still processed as above.
- DRAIN: no new samples are accepted. Leave for DONE once out_valid=0, or on the cycle its handshake completes.
- DONE: done=1 for exactly 1 cycle, then IDLE. sample_count holds until the next start.
- Output slot:
  - out_valid clears only on out_valid & out_ready.
  - out_data is stable while out_valid=1.
  - Load and consume in the same cycle gives back-to-back valid with the new data.
- overrun:
  - clear_overrun=1 clears it unless a drop occurs in the same cycle; the drop wins.
  - Not cleared by start.
- Reset mid-capture returns everything to reset values immediately. Any pending sample is lost.

Optional Feature:
Macro MIC_CTRL_WATCHDOG_EN.
- Defined: a 2-bit counter clears on each accepted sample and on entry to CAPTURE, and increments on each frame_start while in CAPTURE. When it reaches 2, timeout is set (sticky, cleared by start or reset) and the state goes to DRAIN; end of capture proceeds normally with a done pulse.
- Undefined: no watchdog logic; timeout is tied to 0.

Test Plan:
- Reset release, observe 800 cycles → adclrc rises at cycle 1, falls at 193, rises at 385; period 384, 50% duty.
- burst_len=4, start at frame_cnt=100, out_ready=1, rx_valid pulses at frame_cnt=18 with data 0x1234, 0x5678, 0x9ABC, 0xDEF0, and a pulse at frame_cnt=300 before the next frame_start → only post-frame_start pulses accepted; 4 samples out in order; done pulse after the 4th; sample_count=4; overrun=0.
- burst_len=0, out_ready=0, 2 rx_valid → first held in the slot; second dropped; overrun=1; sample_count=1. Then stop plus out_ready=1 → DRAIN, slot drains, done pulse.
- clear_overrun and a dropped sample in the same cycle → overrun stays 1. clear_overrun alone next cycle → 0.
- start pulse during CAPTURE → ignored; burst_len change mid-capture has no effect. Reset_n low mid-CAPTURE with out_valid=1 → all outputs 0 asynchronously.
- With MIC_CTRL_WATCHDOG_EN: CAPTURE with no rx_valid for 2 frame_starts → timeout=1, done pulse, sample_count=0. Without the macro → stays in CAPTURE; timeout=0.

Source files
------------

// File: rtl/mic_capture_ctrl_if.sv
// mic_capture_ctrl_if: receive strobe and downstream ready/valid slot of the capture controller
// Signals: rx_valid/rx_data (sample strobe from the receiver),
//          out_valid/out_data/out_ready (one-entry output slot handshake).
// slave is the controller side, master is the receiver/consumer side.
interface mic_capture_ctrl_if #(
    parameter int N = 16
);
    logic         rx_valid;
    logic [N-1:0] rx_data;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;
    modport master (output rx_valid, rx_data, out_ready, input out_valid, out_data);
    modport slave  (input rx_valid, rx_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: codec ADC capture sequencer with adclrc generation and a one-entry output slot
// Ports: bclk/reset_n (clock, async active-low reset); start/stop/burst_len (capture control,
//        burst_len=0 means continuous); adclrc (frame clock); s (receiver strobe + output slot);
//        busy/done/overrun/clear_overrun/sample_count (status); timeout (watchdog flag).
// Build option: define MIC_CTRL_WATCHDOG_EN to end a capture after 2 frame starts with no sample.
module mic_capture_ctrl #(
    parameter int N           = 16,
    parameter int FRAME_BCLKS = 384,
    parameter int BURST_W     = 16
) (
    input  logic               bclk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    output logic               adclrc,
    mic_capture_ctrl_if.slave  s,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    input  logic               clear_overrun,
    output logic [BURST_W-1:0] sample_count,
    output logic               timeout
);
    localparam int FW = $clog2(FRAME_BCLKS);
    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, DONE} state_t;
    state_t state, nxt;
    logic [FW-1:0] frame_cnt;
    logic [BURST_W-1:0] burst_q, count_inc;
    logic frame_start, accept, drop, to_hit;
    assign frame_start = frame_cnt == '0;
    // the slot is free if empty or being emptied on this same edge
    assign accept = (state == CAPTURE) & s.rx_valid & (~s.out_valid | s.out_ready);
    assign drop = (state == CAPTURE) & s.rx_valid & ~accept;
    assign count_inc = &sample_count ? sample_count : sample_count + BURST_W'(1);
`ifdef MIC_CTRL_WATCHDOG_EN
    logic [1:0] wd_cnt;
    // fires on the frame start that would take the quiet-frame count to 2
    assign to_hit = (state == CAPTURE) & frame_start & ~accept & (wd_cnt == 2'd1);
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (((state == ARM) & frame_start) | accept) wd_cnt <= '0;
            else if ((state == CAPTURE) & frame_start) wd_cnt <= wd_cnt + 2'd1;
            if ((state == IDLE) & start) timeout <= 1'b0;
            else if (to_hit) timeout <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign timeout = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ARM : IDLE;
            ARM:     nxt = frame_start ? CAPTURE : stop ? DONE : ARM;
            CAPTURE: nxt = (stop | to_hit | (accept & (|burst_q) & (count_inc == burst_q))) ? DRAIN : CAPTURE;
            DRAIN:   nxt = (~s.out_valid | s.out_ready) ? DONE : DRAIN;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt    <= '0;
            adclrc       <= 1'b0;
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            s.out_valid  <= 1'b0;
            s.out_data   <= {N{1'b0}};
            overrun      <= 1'b0;
            sample_count <= '0;
            burst_q      <= '0;
        end else begin
            frame_cnt <= (frame_cnt == FW'(FRAME_BCLKS - 1)) ? '0 : frame_cnt + FW'(1);
            adclrc    <= frame_cnt < FW'(FRAME_BCLKS / 2);
            state     <= nxt;
            busy      <= nxt != IDLE;
            done      <= nxt == DONE;
            if ((state == IDLE) & start) begin
                burst_q      <= burst_len;
                sample_count <= '0;
            end
            if (accept) begin
                s.out_valid  <= 1'b1;
                s.out_data   <= s.rx_data;
                sample_count <= count_inc;
            end else if (s.out_valid & s.out_ready) begin
                s.out_valid <= 1'b0;
            end
            overrun <= drop | (overrun & ~clear_overrun);
        end
    end
endmodule
